cfg_entry_ctrl: RTL and testbench

- Front-panel configuration entry stage directly upstream of the bus top level.
- Conditions one raw active-low push-button (synchronise, debounce, single-pulse).
- In config mode, each press latches the 12-bit switch array into the next of NUM_FIELDS configuration registers, stepping 0..NUM_FIELDS-1 and wrapping.
- Registered fields drive the bus masters' address, data, burst and slave-select settings.

---
 rtl/cfg_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 62 ++++++
 rtl/cfg_entry_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cfg_entry_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared definitions for the front-panel configuration entry stage:
// FSM state type, field index map and default geometry.
package cfg_pkg;

  localparam int CFG_DATA_W     = 12;
  localparam int CFG_NUM_FIELDS = 7;

  // Field map as seen by the bus top level
  localparam int FLD_M1_ADDR = 0;
  localparam int FLD_M1_DATA = 1;
  localparam int FLD_BURST   = 2;
  localparam int FLD_SLV_SEL = 3;
  localparam int FLD_M2_ADDR = 4;
  localparam int FLD_M2_DATA = 5;
  localparam int FLD_SPLIT   = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    CONFIG = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-sample debounce
// counter and single-cycle press pulse on the debounced falling edge.
// The button is active-low; the released level is 1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
)(
  input  logic clock,
  input  logic rst,
  input  logic i_enable,
  input  logic i_btn_n,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             w_diff;
  logic             w_flip;

  assign w_diff = r_sync2 ^ r_level;
  assign w_flip = w_diff && (r_cnt == CNT_MAX);

  // Synchroniser runs every cycle so the sample is fresh when enable returns
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce counter and accepted level; pulse is lost while disabled
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else if (i_enable) begin
      if (w_flip) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt   <= r_cnt + 1'b1;
      end else begin
        r_cnt   <= '0;
      end
      r_press <= w_flip && !r_sync2;
    end else begin
      r_press <= 1'b0;
    end
  end

  assign o_press = r_press && i_enable;

endmodule

// File: rtl/cfg_entry_ctrl.sv
// Front-panel configuration entry: each accepted press in config mode
// latches switch_array into the next configuration field, wrapping after
// the last one. Optional macro CFG_READBACK_EN adds cfg_rd, a registered
// copy of the field currently addressed by field_idx.
module cfg_entry_ctrl
  import cfg_pkg::*;
#(
  parameter int DATA_W          = CFG_DATA_W,
  parameter int NUM_FIELDS      = CFG_NUM_FIELDS,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int IDX_W           = 3
)(
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         button_raw,
  input  logic                         mode_switch,
  input  logic [DATA_W-1:0]            switch_array,
  output logic [NUM_FIELDS*DATA_W-1:0] cfg_fields,
  output logic [IDX_W-1:0]             field_idx,
  output logic                         press_pulse,
  output logic                         cfg_wr,
  output logic                         cfg_done
`ifdef CFG_READBACK_EN
  ,
  output logic [DATA_W-1:0]            cfg_rd
`endif
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FIELDS - 1);

  logic              w_press;
  logic              r_mode_s1;
  logic              r_mode_s2;
  cfg_state_t        r_state;
  cfg_state_t        w_state_nxt;
  logic              w_wr_en;
  logic              w_idx_clr;
  logic [IDX_W-1:0]  r_idx;
  logic              r_cfg_wr;
  logic              r_cfg_done;
  logic [DATA_W-1:0] r_fields [NUM_FIELDS];

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clock    (clock),
    .rst      (rst),
    .i_enable (enable),
    .i_btn_n  (button_raw),
    .o_press  (w_press)
  );

  // Mode switch synchroniser; resets to run mode until the pin is sampled
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_mode_s1 <= 1'b1;
      r_mode_s2 <= 1'b1;
    end else begin
      r_mode_s1 <= mode_switch;
      r_mode_s2 <= r_mode_s1;
    end
  end

  // FSM state register, frozen while disabled
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (enable) begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and write decision; the mode sampled this cycle decides a press
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_idx_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_mode_s2) begin
          w_state_nxt = CONFIG;
          w_wr_en     = w_press;
        end
      end
      CONFIG: begin
        if (r_mode_s2) begin
          w_state_nxt = IDLE;
          w_idx_clr   = 1'b1;
        end else begin
          w_wr_en     = w_press;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Field index: steps on every write, wraps after the last field
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (enable) begin
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_wr_en) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Write/done strobes follow the write by one cycle, aligned with the new field
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_cfg_wr   <= 1'b0;
      r_cfg_done <= 1'b0;
    end else if (enable) begin
      r_cfg_wr   <= w_wr_en;
      r_cfg_done <= w_wr_en && (r_idx == IDX_LAST);
    end else begin
      r_cfg_wr   <= 1'b0;
      r_cfg_done <= 1'b0;
    end
  end

  // Configuration field registers
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_FIELDS; k++) begin
        r_fields[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_FIELDS; k++) begin
        if (w_wr_en && (r_idx == IDX_W'(k))) begin
          r_fields[k] <= switch_array;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_pack
    assign cfg_fields[g*DATA_W +: DATA_W] = r_fields[g];
  end

  assign field_idx   = r_idx;
  assign press_pulse = w_press;
  assign cfg_wr      = r_cfg_wr && enable;
  assign cfg_done    = r_cfg_done && enable;

`ifdef CFG_READBACK_EN
  logic [DATA_W-1:0] w_rd_sel;
  logic [DATA_W-1:0] r_cfg_rd;

  // Select the field addressed by the current index
  always_comb begin
    w_rd_sel = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_rd_sel = r_fields[k];
      end
    end
  end

  // Registered readback for the LED display
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_cfg_rd <= '0;
    end else begin
      r_cfg_rd <= w_rd_sel;
    end
  end

  assign cfg_rd = r_cfg_rd;
`endif

endmodule

// File: tb/tb_cfg_entry_ctrl.sv
// Directed bench for cfg_entry_ctrl with hand-computed expectations.
module tb_cfg_entry_ctrl;

  localparam int DATA_W = 12;
  localparam int NF     = 7;
  localparam int DC     = 4;
  localparam int IDX_W  = 3;

  logic               clock = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b1;
  logic               button_raw = 1'b1;
  logic               mode_switch = 1'b0;
  logic [DATA_W-1:0]  switch_array = '0;
  logic [NF*DATA_W-1:0] cfg_fields;
  logic [IDX_W-1:0]   field_idx;
  logic               press_pulse;
  logic               cfg_wr;
  logic               cfg_done;
`ifdef CFG_READBACK_EN
  logic [DATA_W-1:0]  cfg_rd;
`endif

  int checks = 0;
  int failures = 0;
  int n_press = 0;
  int n_wr = 0;
  int n_done = 0;
  int done_idx = -1;
  int idx_log[$];
  logic [DATA_W-1:0] exp_f [NF];

  cfg_entry_ctrl #(
    .DATA_W          (DATA_W),
    .NUM_FIELDS      (NF),
    .DEBOUNCE_CYCLES (DC),
    .IDX_W           (IDX_W)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .enable       (enable),
    .button_raw   (button_raw),
    .mode_switch  (mode_switch),
    .switch_array (switch_array),
    .cfg_fields   (cfg_fields),
    .field_idx    (field_idx),
    .press_pulse  (press_pulse),
    .cfg_wr       (cfg_wr),
    .cfg_done     (cfg_done)
`ifdef CFG_READBACK_EN
    ,
    .cfg_rd       (cfg_rd)
`endif
  );

  always #5 clock = ~clock;

  // Event monitor sampled on the inactive edge
  always @(negedge clock) begin
    if (press_pulse) n_press++;
    if (cfg_wr) begin
      n_wr++;
      idx_log.push_back(int'(field_idx));
    end
    if (cfg_done) begin
      n_done++;
      done_idx = int'(field_idx);
    end
  end

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [NF*DATA_W-1:0] pack_exp();
    logic [NF*DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < NF; k++) v[k*DATA_W +: DATA_W] = exp_f[k];
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input int hold, input int gap);
    button_raw = 1'b0;
    cyc(hold);
    button_raw = 1'b1;
    cyc(gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_press, b_wr, b_done, base, lat;

    for (int k = 0; k < NF; k++) exp_f[k] = '0;

    // Reset state
    cyc(3);
    chk("rst_fields", 96'(cfg_fields), 96'(0));
    chk("rst_idx", 96'(field_idx), 96'(0));
    chk("rst_pulses", 96'({press_pulse, cfg_wr, cfg_done}), 96'(0));
    rst = 1'b0;

    // Idle for 100 cycles: nothing happens
    b_press = n_press; b_wr = n_wr;
    cyc(100);
    chk("idle_press", 96'(n_press - b_press), 96'(0));
    chk("idle_wr", 96'(n_wr - b_wr), 96'(0));
    chk("idle_fields", 96'(cfg_fields), 96'(0));
    chk("idle_idx", 96'(field_idx), 96'(0));

    // Seven presses of 129
    switch_array = 12'd129;
    b_press = n_press; b_wr = n_wr; b_done = n_done; base = idx_log.size();
    for (int i = 0; i < NF; i++) press(10, 10);
    for (int k = 0; k < NF; k++) exp_f[k] = 12'd129;
    chk("seq_fields", 96'(cfg_fields), 96'(pack_exp()));
    chk("seq_press", 96'(n_press - b_press), 96'(7));
    chk("seq_wr", 96'(n_wr - b_wr), 96'(7));
    chk("seq_done", 96'(n_done - b_done), 96'(1));
    chk("seq_done_idx", 96'(done_idx), 96'(0));
    for (int i = 0; i < NF; i++) begin
      if (idx_log.size() > base + i)
        chk($sformatf("seq_idx%0d", i), 96'(idx_log[base+i]), 96'((i + 1) % NF));
      else
        chk($sformatf("seq_idx%0d_missing", i), 96'(1), 96'(0));
    end

    // Short glitch is rejected
    b_press = n_press;
    button_raw = 1'b0; cyc(2); button_raw = 1'b1; cyc(20);
    chk("glitch_press", 96'(n_press - b_press), 96'(0));
    chk("glitch_fields", 96'(cfg_fields), 96'(pack_exp()));

    // Long hold: one pulse, latency DC+2, writes field 0
    switch_array = 12'd77;
    b_press = n_press;
    button_raw = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (press_pulse) begin
        lat = i;
        break;
      end
    end
    chk("press_latency", 96'(lat), 96'(DC + 2));
    cyc(200 - lat);
    button_raw = 1'b1;
    cyc(20);
    exp_f[0] = 12'd77;
    chk("held_one_pulse", 96'(n_press - b_press), 96'(1));
    chk("held_fields", 96'(cfg_fields), 96'(pack_exp()));
    chk("held_idx", 96'(field_idx), 96'(1));

    // Leaving config mode clears the index
    mode_switch = 1'b1; cyc(5);
    chk("run_idx_clr", 96'(field_idx), 96'(0));
    mode_switch = 1'b0; cyc(5);

    // Latch 10, 0, 5
    switch_array = 12'd10; press(10, 10);
    switch_array = 12'd0;  press(10, 10);
    switch_array = 12'd5;  press(10, 10);
    exp_f[0] = 12'd10; exp_f[1] = 12'd0; exp_f[2] = 12'd5;
    chk("three_fields", 96'(cfg_fields), 96'(pack_exp()));
    chk("three_idx", 96'(field_idx), 96'(3));

    // Run mode: fields retained, press gives pulse but no write
    mode_switch = 1'b1; cyc(5);
    chk("run_idx", 96'(field_idx), 96'(0));
    chk("run_fields", 96'(cfg_fields), 96'(pack_exp()));
    switch_array = 12'd999;
    b_press = n_press; b_wr = n_wr;
    press(10, 10);
    chk("run_press", 96'(n_press - b_press), 96'(1));
    chk("run_wr", 96'(n_wr - b_wr), 96'(0));
    chk("run_fields_after", 96'(cfg_fields), 96'(pack_exp()));
    mode_switch = 1'b0; cyc(5);

    // Disabled during a press
    b_press = n_press; b_wr = n_wr;
    enable = 1'b0;
    button_raw = 1'b0; cyc(15);
    button_raw = 1'b1; cyc(15);
    enable = 1'b1; cyc(15);
    chk("dis_press", 96'(n_press - b_press), 96'(0));
    chk("dis_wr", 96'(n_wr - b_wr), 96'(0));
    chk("dis_fields", 96'(cfg_fields), 96'(pack_exp()));

    // Reset mid-entry at index 4
    switch_array = 12'd300;
    for (int i = 0; i < 4; i++) press(10, 10);
    for (int k = 0; k < 4; k++) exp_f[k] = 12'd300;
    chk("mid_fields", 96'(cfg_fields), 96'(pack_exp()));
    chk("mid_idx", 96'(field_idx), 96'(4));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_fields", 96'(cfg_fields), 96'(0));
    chk("async_rst_idx", 96'(field_idx), 96'(0));
    cyc(3);
    rst = 1'b0;
    cyc(5);

`ifdef CFG_READBACK_EN
    chk("rd_reset", 96'(cfg_rd), 96'(0));
    switch_array = 12'h0AB; press(10, 10);
    switch_array = 12'h123; press(10, 10);
    chk("rd_idx2", 96'(cfg_rd), 96'(0));
    switch_array = 12'h055;
    for (int i = 0; i < 5; i++) press(10, 10);
    chk("rd_wrap_idx", 96'(field_idx), 96'(0));
    chk("rd_field0", 96'(cfg_rd), 96'(12'h0AB));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
